// File: rtl/fetch_pc_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_pkg
//  Shared constants and types for the fetch-stage PC logic.
//   PC_STEP        : sequential PC increment (one 32-bit instruction word)
//   IJ             : opcode of the direct jump instruction (J)
//   fetch_state_e  : fetch controller states BOOT / RUN / STALL / HALT
//   jump_target()  : J-format target, region bits taken from PC+4
// ----------------------------------------------------------------------------
package fetch_pc_pkg;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [5:0]  IJ      = 6'h02;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_STALL = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    // J keeps the 256 MB region of the delay-slot address and replaces the
    // rest with the word-aligned instruction index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] instr_index);
        return {pc_plus4[31:28], instr_index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_mux.sv
// ----------------------------------------------------------------------------
// fetch_pc_mux
//  Combinational next-PC / next-state selection for the fetch stage plus the
//  instruction-memory range check. Priority (reset is applied by the parent):
//  M_redirect > F_stall > jump > sequential.
//  Optional feature macro: FETCH_JUMP_PREDICT_EN (when defined, a J seen on a
//  valid fetch slot redirects fetch immediately; otherwise J is sequential).
//  Ports:
//   state_q      in   current fetch state
//   pc_q         in   current fetch PC
//   pc_plus4     in   pc_q + 4
//   F_stall      in   hold request from the hazard unit
//   M_redirect   in   redirect request from the memory stage
//   M_target     in   redirect target (low two bits ignored)
//   f_op         in   opcode of the instruction at pc_q
//   f_valC       in   immediate; [25:0] is the J instruction index
//   state_d      out  next fetch state
//   pc_d         out  next fetch PC
// ----------------------------------------------------------------------------
module fetch_pc_mux
    import fetch_pc_pkg::*;
#(
    parameter int IMEM_WORDS = 16
) (
    input  fetch_state_e state_q,
    input  logic [31:0]  pc_q,
    input  logic [31:0]  pc_plus4,
    input  logic         F_stall,
    input  logic         M_redirect,
    input  logic [31:0]  M_target,
    input  logic [5:0]   f_op,
    input  logic [31:0]  f_valC,
    output fetch_state_e state_d,
    output logic [31:0]  pc_d
);

    localparam logic [31:0] LAST_PC = 32'(4 * (IMEM_WORDS - 1));

    logic [31:0] redirect_pc;
    logic [31:0] advance_pc;
    logic        take_jump;

    // Misaligned redirect targets are silently aligned down.
    assign redirect_pc = {M_target[31:2], 2'b00};

`ifdef FETCH_JUMP_PREDICT_EN
    assign take_jump = (f_op == IJ);
    logic unused_bits;
    assign unused_bits = ^{M_target[1:0], f_valC[31:26]};
`else
    assign take_jump = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{M_target[1:0], f_op, f_valC};
`endif

    assign advance_pc = take_jump ? jump_target(pc_plus4, f_valC[25:0]) : pc_plus4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (M_redirect) begin
            // A redirect overrides stall and is the only way out of HALT.
            // An out-of-range target halts with the PC left where it was.
            if (redirect_pc <= LAST_PC) begin
                pc_d    = redirect_pc;
                state_d = FS_RUN;
            end else begin
                state_d = FS_HALT;
            end
        end else begin
            unique case (state_q)
                FS_BOOT: state_d = FS_RUN;   // first PC is presented, not skipped
                FS_HALT: state_d = FS_HALT;
                default: begin               // FS_RUN, FS_STALL
                    if (F_stall) begin
                        state_d = FS_STALL;
                    end else if (advance_pc <= LAST_PC) begin
                        pc_d    = advance_pc;
                        state_d = FS_RUN;
                    end else begin
                        state_d = FS_HALT;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// ----------------------------------------------------------------------------
// fetch_pc
//  Fetch-stage PC register and fetch state register. Next-PC selection lives
//  in fetch_pc_mux; this module only registers its result (one-cycle latency,
//  no combinational path from f_op to F_valP).
//  Optional feature macro: FETCH_JUMP_PREDICT_EN (early J redirection).
//  Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   synchronous active-high reset
//   F_stall      in   hold PC this cycle
//   M_redirect   in   memory-stage redirect
//   M_target     in   redirect target
//   f_op         in   opcode of instruction at F_valP
//   f_valC       in   immediate / J instruction index
//   F_valP       out  current fetch PC
//   F_valid      out  F_valP addresses a real instruction
//   f_pc_plus4   out  F_valP + 4
//   F_halted     out  PC left the legal instruction memory range
// ----------------------------------------------------------------------------
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        M_redirect,
    input  logic [31:0] M_target,
    input  logic [5:0]  f_op,
    input  logic [31:0] f_valC,
    output logic [31:0] F_valP,
    output logic        F_valid,
    output logic [31:0] f_pc_plus4,
    output logic        F_halted
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    assign f_pc_plus4 = pc_q + PC_STEP;

    fetch_pc_mux #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_mux (
        .state_q    (state_q),
        .pc_q       (pc_q),
        .pc_plus4   (f_pc_plus4),
        .F_stall    (F_stall),
        .M_redirect (M_redirect),
        .M_target   (M_target),
        .f_op       (f_op),
        .f_valC     (f_valC),
        .state_d    (state_d),
        .pc_d       (pc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign F_valP   = pc_q;
    assign F_valid  = (state_q == FS_RUN) || (state_q == FS_STALL);
    assign F_halted = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_pc.sv
module tb_fetch_pc;
    import fetch_pc_pkg::*;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] LAST_PC = 32'd60;

    logic        clk = 1'b0;
    logic        rst, F_stall, M_redirect;
    logic [31:0] M_target, f_valC;
    logic [5:0]  f_op;
    logic [31:0] F_valP, f_pc_plus4;
    logic        F_valid, F_halted;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference: PC plus two flags (still booting / halted).
    logic [31:0] m_pc;
    logic        m_boot, m_halt;

    always #5 clk = ~clk;

    fetch_pc #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .F_stall    (F_stall),
        .M_redirect (M_redirect),
        .M_target   (M_target),
        .f_op       (f_op),
        .f_valC     (f_valC),
        .F_valP     (F_valP),
        .F_valid    (F_valid),
        .f_pc_plus4 (f_pc_plus4),
        .F_halted   (F_halted)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic st, input logic red,
                              input logic [31:0] tgt, input logic [5:0] op,
                              input logic [31:0] valc);
        logic [31:0] t, nxt, pc4;
        pc4 = m_pc + 32'd4;
        if (r) begin
            m_pc = RST_PC; m_boot = 1'b1; m_halt = 1'b0;
        end else if (red) begin
            t = tgt & 32'hFFFF_FFFC;
            m_boot = 1'b0;
            if (t <= LAST_PC) begin
                m_pc = t; m_halt = 1'b0;
            end else begin
                m_halt = 1'b1;
            end
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_halt && !st) begin
            nxt = pc4;
`ifdef FETCH_JUMP_PREDICT_EN
            if (op == 6'h02) nxt = (pc4 & 32'hF000_0000) | ((valc & 32'h03FF_FFFF) * 4);
`endif
            if (nxt <= LAST_PC) m_pc = nxt;
            else m_halt = 1'b1;
        end
    endtask

    task automatic cyc(input logic r, input logic st, input logic red,
                       input logic [31:0] tgt, input logic [5:0] op, input logic [31:0] valc);
        rst = r; F_stall = st; M_redirect = red; M_target = tgt; f_op = op; f_valC = valc;
        @(posedge clk);
        model_step(r, st, red, tgt, op, valc);
        #1;
        check_val("F_valP", F_valP, m_pc);
        check_val("F_valid", {31'd0, F_valid}, {31'd0, !m_boot && !m_halt});
        check_val("F_halted", {31'd0, F_halted}, {31'd0, m_halt});
        check_val("f_pc_plus4", f_pc_plus4, m_pc + 32'd4);
        $display("t=%0t rst=%b st=%b red=%b tgt=%h op=%h valC=%h -> pc=%h v=%b h=%b",
                 $time, r, st, red, tgt, op, valc, F_valP, F_valid, F_halted);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 6'h00, 32'd0);
    endtask

    initial begin
        m_pc = RST_PC; m_boot = 1'b1; m_halt = 1'b0;

        // 1: reset two cycles, boot, then sequential stepping
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 6'h00, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h30, IJ, 32'h7);   // reset wins over everything
        idle(3);                                   // 0 (valid), 4, 8
        check_val("dir_pc8", F_valP, 32'd8);
        // 2: stall three cycles at 8, then resume at 12
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0, 6'h00, 32'd0);
        check_val("dir_stall_hold", F_valP, 32'd8);
        idle(1);
        check_val("dir_resume", F_valP, 32'd12);
        // 3: redirect beats stall
        cyc(1'b0, 1'b1, 1'b1, 32'h20, 6'h00, 32'd0);
        check_val("dir_redirect", F_valP, 32'h20);
        // 4: run off the end of imem, then recover via redirect (misaligned)
        idle(7);
        check_val("dir_pc60", F_valP, 32'd60);
        idle(3);
        check_val("dir_halt", {31'd0, F_halted}, 32'd1);
        check_val("dir_frozen", F_valP, 32'd60);
        cyc(1'b0, 1'b0, 1'b1, 32'h7, 6'h00, 32'd0);
        check_val("dir_unhalt", F_valP, 32'h4);
        // 5: J at PC 0
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 6'h00, 32'd0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, IJ, 32'h5);
`ifdef FETCH_JUMP_PREDICT_EN
        check_val("dir_jump", F_valP, 32'h14);
`else
        check_val("dir_jump", F_valP, 32'h4);
`endif
        // 6: reset in the middle of a stall at 24
        cyc(1'b0, 1'b0, 1'b1, 32'd24, 6'h00, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 6'h00, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 6'h00, 32'd0);
        check_val("dir_rst_mid_stall", F_valP, RST_PC);

        // Random phase
        for (int i = 0; i < 1500; i++) begin
            logic        r, st, red;
            logic [31:0] tgt, valc;
            logic [5:0]  op;
            r    = ($urandom_range(0, 99) < 2);
            st   = ($urandom_range(0, 99) < 25);
            red  = ($urandom_range(0, 99) < 8);
            tgt  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 72));
            op   = ($urandom_range(0, 4) == 0) ? IJ : 6'($urandom_range(0, 63));
            valc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 17));
            cyc(r, st, red, tgt, op, valc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
